// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the fetch stage and the decoder it feeds.
package inst_fetch_pkg;

  localparam int INST_W    = 32;
  localparam int ENTRY_W   = 64;  // {pc, inst}

  // Field positions shared with decode.
  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_FETCH = 2'd1,
    IF_DRAIN = 2'd2,
    IF_DONE  = 2'd3
  } if_state_e;

endpackage

// File: rtl/inst_fifo2.sv
// Two-entry FIFO holding fetched {pc, inst} pairs; head reads 0 when empty.
module inst_fifo2 #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] entry0_q, entry0_d;
  logic [W-1:0] entry1_q, entry1_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q,  count_d;
  logic         do_push;
  logic         do_pop;

  // Next-state: write at wr_ptr, advance rd_ptr on pop, track occupancy.
  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != 2'd0);
    // A full FIFO may only accept a push when the head leaves in the same cycle.
    do_push  = push && ((count_q != 2'd2) || do_pop);
    if (do_push) begin
      if (wr_ptr_q) entry1_d = push_data;
      else          entry0_d = push_data;
      wr_ptr_d = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry0_q <= '0;
      entry1_q <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = (count_q == 2'd0) ? '0 : (rd_ptr_q ? entry1_q : entry0_q);

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: walks the PC through a synchronous-read memory, buffers
// words in a 2-entry queue and hands them to decode over valid/ready.
//
// Handshake: a word transfers on every rising edge where out_valid and
// out_ready are both high; while out_valid is high and out_ready low, every
// output (out_inst, out_pc, op_o, funct_o) holds its value.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int          ADDR_W     = 10,
  parameter int          INST_COUNT = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [31:0]       out_pc,
  output logic [5:0]        op_o,
  output logic [5:0]        funct_o,
  output logic              done
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] INST_CNT_L = INST_COUNT[CNT_W-1:0];

  if_state_e        state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic             inflight_q, inflight_d;
  logic [31:0]      inflight_pc_q, inflight_pc_d;

  logic [1:0]       fifo_count;
  logic [ENTRY_W-1:0] fifo_head;
  logic             pop;
  logic [2:0]       occ;
  logic             credit;
  logic             issue;

  // Issue decision and next-state logic for the fetch FSM and PC walker.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    issued_d      = issued_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;

    pop    = (fifo_count != 2'd0) && out_ready;
    // Words already owed to the queue, less the one leaving this cycle.
    occ    = {1'b0, fifo_count} + {2'b00, inflight_q};
    credit = (occ - {2'b00, pop}) < 3'd2;
    issue  = (state_q == IF_FETCH) && run && (issued_q < INST_CNT_L) && credit;

    if (issue) begin
      pc_d          = pc_q + 32'd4;
      issued_d      = issued_q + {{(CNT_W-1){1'b0}}, 1'b1};
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end

    case (state_q)
      IF_IDLE: begin
        if (run) state_d = (INST_COUNT == 0) ? IF_DRAIN : IF_FETCH;
      end
      IF_FETCH: begin
        if (issue && (issued_d == INST_CNT_L)) state_d = IF_DRAIN;
      end
      IF_DRAIN: begin
        // Finish as soon as the last word leaves, so done follows the final handshake.
        if (!inflight_q && ((fifo_count - {1'b0, pop}) == 2'd0)) state_d = IF_DONE;
      end
      IF_DONE: begin
        state_d = IF_DONE;
      end
      default: state_d = IF_IDLE;
    endcase
  end

  // Fetch state registers; reset also drops any read still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IF_IDLE;
      pc_q          <= RESET_PC;
      issued_q      <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      issued_q      <= issued_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  inst_fifo2 #(
    .W(ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data ({inflight_pc_q, imem_rdata}),
    .pop       (pop),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign imem_en   = issue;
  assign imem_addr = pc_q[ADDR_W+1:2];
  assign out_valid = (fifo_count != 2'd0);
  assign out_inst  = fifo_head[INST_W-1:0];
  assign out_pc    = fifo_head[ENTRY_W-1:INST_W];
  assign op_o      = out_inst[OP_MSB:OP_LSB];
  assign funct_o   = out_inst[FUNCT_MSB:FUNCT_LSB];
  assign done      = (state_q == IF_DONE);

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed timeline checks plus a randomized run
// scored against an in-order list of expected {pc, inst} deliveries.
module tb_inst_fetch;

  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- instance S: 4-instruction stream from PC 0 ----------------
  logic          s_rst, s_run, s_en, s_valid, s_ready, s_done;
  logic [AW-1:0] s_addr;
  logic [31:0]   s_rdata, s_inst, s_pc;
  logic [5:0]    s_op, s_funct;
  logic [31:0]   mem_s [16];

  inst_fetch #(.ADDR_W(AW), .INST_COUNT(4), .RESET_PC(32'h0)) dut_s (
    .clk(clk), .rst(s_rst), .run(s_run), .imem_en(s_en), .imem_addr(s_addr),
    .imem_rdata(s_rdata), .out_valid(s_valid), .out_ready(s_ready),
    .out_inst(s_inst), .out_pc(s_pc), .op_o(s_op), .funct_o(s_funct), .done(s_done)
  );

  // ---------------- instance R: 12 instructions, address wraps ----------------
  localparam logic [31:0] R_PC0 = 32'h0000_0038;
  localparam int          R_N   = 12;
  logic          r_rst, r_run, r_en, r_valid, r_ready, r_done;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_rdata, r_inst, r_pc;
  logic [5:0]    r_op, r_funct;
  logic [31:0]   mem_r [16];

  inst_fetch #(.ADDR_W(AW), .INST_COUNT(R_N), .RESET_PC(R_PC0)) dut_r (
    .clk(clk), .rst(r_rst), .run(r_run), .imem_en(r_en), .imem_addr(r_addr),
    .imem_rdata(r_rdata), .out_valid(r_valid), .out_ready(r_ready),
    .out_inst(r_inst), .out_pc(r_pc), .op_o(r_op), .funct_o(r_funct), .done(r_done)
  );

  // ---------------- instance Z: zero instructions ----------------
  logic          z_rst, z_run, z_en, z_valid, z_ready, z_done;
  logic [AW-1:0] z_addr;
  logic [31:0]   z_rdata, z_inst, z_pc;
  logic [5:0]    z_op, z_funct;

  inst_fetch #(.ADDR_W(AW), .INST_COUNT(0), .RESET_PC(32'h10)) dut_z (
    .clk(clk), .rst(z_rst), .run(z_run), .imem_en(z_en), .imem_addr(z_addr),
    .imem_rdata(z_rdata), .out_valid(z_valid), .out_ready(z_ready),
    .out_inst(z_inst), .out_pc(z_pc), .op_o(z_op), .funct_o(z_funct), .done(z_done)
  );

  // Synchronous-read memories; garbage on idle cycles exposes capture slips.
  always @(posedge clk) begin
    s_rdata <= s_en ? mem_s[s_addr] : $urandom;
    r_rdata <= r_en ? mem_r[r_addr] : $urandom;
    z_rdata <= $urandom;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] exp_q [$];
  logic [63:0] exp_e;

  initial begin : main
    int issued, delivered, stall_issues, last_c;
    logic        hold;
    logic [31:0] hold_inst, hold_pc;
    logic [3:0]  exp_addr;
    logic [31:0] epc;
    bit          pop_now;

    s_rst = 1'b1; s_run = 1'b0; s_ready = 1'b0;
    r_rst = 1'b1; r_run = 1'b0; r_ready = 1'b0;
    z_rst = 1'b1; z_run = 1'b0; z_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      mem_s[i] = 32'hDEAD_0000 | i;
      mem_r[i] = $urandom;
    end
    mem_s[0] = 32'h2008_0005;
    mem_s[1] = 32'h0109_5020;
    mem_s[2] = 32'h0000_0000;
    mem_s[3] = 32'h3C0A_FFFF;

    // ---- reset then idle ----
    next_cycle();
    check("rst_en",    {31'b0, s_en},    32'd0);
    check("rst_addr",  {28'b0, s_addr},  32'd0);
    check("rst_valid", {31'b0, s_valid}, 32'd0);
    check("rst_inst",  s_inst,           32'd0);
    check("rst_pc",    s_pc,             32'd0);
    check("rst_done",  {31'b0, s_done},  32'd0);
    next_cycle();
    s_rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("idle_en",    {31'b0, s_en},    32'd0);
      check("idle_valid", {31'b0, s_valid}, 32'd0);
      check("idle_done",  {31'b0, s_done},  32'd0);
      next_cycle();
    end

    // ---- streaming: words in cycles 3..6, done from cycle 7 ----
    s_rst = 1'b1;
    repeat (2) next_cycle();
    s_rst = 1'b0; s_run = 1'b1; s_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("strm_en", {31'b0, s_en}, {31'b0, (c >= 1 && c <= 4)});
      if (s_en) check("strm_addr", {28'b0, s_addr}, c - 1);
      check("strm_valid", {31'b0, s_valid}, {31'b0, (c >= 3 && c <= 6)});
      if (c >= 3 && c <= 6) begin
        check("strm_pc",   s_pc,   4 * (c - 3));
        check("strm_inst", s_inst, mem_s[c - 3]);
      end else begin
        check("strm_empty_inst", s_inst, 32'd0);
      end
      if (c == 3) begin
        check("strm_op",    {26'b0, s_op},    32'h08);
        check("strm_funct", {26'b0, s_funct}, 32'h05);
      end
      check("strm_done", {31'b0, s_done}, {31'b0, (c >= 7)});
      next_cycle();
    end

    // ---- reset with one word queued and one read in flight ----
    s_rst = 1'b1; s_run = 1'b0; s_ready = 1'b0;
    repeat (2) next_cycle();
    s_rst = 1'b0; s_run = 1'b1;
    repeat (3) next_cycle();
    @(negedge clk);  // cycle 3: word 0 queued, word 1 in flight
    check("mid_valid", {31'b0, s_valid}, 32'd1);
    check("mid_inst",  s_inst,           mem_s[0]);
    check("mid_noiss", {31'b0, s_en},    32'd0);
    s_rst = 1'b1; s_run = 1'b0;
    next_cycle();
    s_rst = 1'b0; s_ready = 1'b1;
    @(negedge clk);
    check("mrst_valid", {31'b0, s_valid}, 32'd0);
    check("mrst_addr",  {28'b0, s_addr},  32'd0);
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      @(negedge clk);
      check("mrst_never_valid", {31'b0, s_valid}, 32'd0);
      check("mrst_no_en",       {31'b0, s_en},    32'd0);
    end

    // ---- INST_COUNT = 0: IDLE -> DRAIN -> DONE, no requests ----
    next_cycle();
    z_rst = 1'b0; z_run = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("zero_en",    {31'b0, z_en},    32'd0);
      check("zero_valid", {31'b0, z_valid}, 32'd0);
      check("zero_done",  {31'b0, z_done},  {31'b0, (c >= 2)});
      next_cycle();
    end

    // ---- randomized run with pause and backpressure windows ----
    exp_q.delete();
    for (int k = 0; k < R_N; k++) begin
      epc = R_PC0 + 32'(4 * k);
      exp_q.push_back({epc, mem_r[epc[5:2]]});
    end
    issued = 0; delivered = 0; stall_issues = 0; last_c = -1;
    hold = 1'b0; hold_inst = '0; hold_pc = '0;
    r_rst = 1'b1;
    repeat (2) next_cycle();
    r_rst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      r_run   = (c >= 8 && c <= 10) ? 1'b0 : ($urandom_range(0, 7) != 0);
      r_ready = (c >= 14 && c <= 19) ? 1'b0 : ($urandom_range(0, 3) != 0);
      @(negedge clk);
      check("rnd_done", {31'b0, r_done}, {31'b0, (delivered == R_N)});
      if (!r_run) check("rnd_pause_en", {31'b0, r_en}, 32'd0);
      if (r_en) begin
        exp_addr = 4'((R_PC0 >> 2) + 32'(issued));
        check("rnd_addr", {28'b0, r_addr}, {28'b0, exp_addr});
        issued++;
        if (c >= 14 && c <= 19) stall_issues++;
      end
      if (hold) begin
        check("rnd_hold_valid", {31'b0, r_valid}, 32'd1);
        check("rnd_hold_inst",  r_inst, hold_inst);
        check("rnd_hold_pc",    r_pc,   hold_pc);
      end
      pop_now = r_valid && r_ready;
      if (pop_now) begin
        if (exp_q.size() == 0) begin
          check("rnd_extra_word", r_pc, 32'hFFFF_FFFF);
        end else begin
          exp_e = exp_q.pop_front();
          check("rnd_pc",    r_pc,   exp_e[63:32]);
          check("rnd_inst",  r_inst, exp_e[31:0]);
          check("rnd_op",    {26'b0, r_op},    {26'b0, exp_e[31:26]});
          check("rnd_funct", {26'b0, r_funct}, {26'b0, exp_e[5:0]});
        end
        delivered++;
        last_c = c;
      end
      if (!r_valid) check("rnd_empty_inst", r_inst, 32'd0);
      check("rnd_outstanding", {31'b0, ((issued - delivered) <= 2)}, 32'd1);
      if (c == 20) check("rnd_stall_issues", {31'b0, (stall_issues <= 2)}, 32'd1);
      hold      = r_valid && !r_ready;
      hold_inst = r_inst;
      hold_pc   = r_pc;
      next_cycle();
      if (delivered == R_N && c > last_c + 2 && c > 20) break;
    end
    @(negedge clk);
    check("rnd_all_delivered", delivered, R_N);
    check("rnd_issued",        issued,    R_N);
    check("rnd_queue_empty",   exp_q.size(), 32'd0);
    check("rnd_final_done",    {31'b0, r_done}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
